// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one bridge request port between ICache and DCache miss ports
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE = 0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    inst_ce,
  input  logic                    inst_we,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  input  logic [DATA_WIDTH-1:0]   inst_wdata,
  input  logic [DATA_WIDTH/8-1:0] inst_wmask,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  output logic                    inst_rdata_valid,
  output logic                    inst_write_finish,
  input  logic                    data_ce,
  input  logic                    data_we,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_wmask,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    data_rdata_valid,
  output logic                    data_write_finish,
  output logic                    mem_ce,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_rdata_valid,
  input  logic                    mem_write_finish,
  output logic [CNT_WIDTH-1:0]    grant_cnt_inst,
  output logic [CNT_WIDTH-1:0]    grant_cnt_data
);
  typedef enum logic [1:0] {IDLE, INST_BUSY, DATA_BUSY, INST_DRAIN} state_t;
  state_t state, state_nx;
  logic lat_we, last_data, pick_data, pick_inst, busy, done;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH/8-1:0] lat_wmask;
  // arbitration, completion detection and next state
  always_comb begin
    pick_data = (ARB_MODE == 0) ? data_ce : data_ce && (!inst_ce || !last_data);
    pick_inst = inst_ce && !pick_data;
    busy = state != IDLE;
    done = busy && (lat_we ? mem_write_finish : mem_rdata_valid);
    state_nx = !busy ? (pick_data ? DATA_BUSY : pick_inst ? INST_BUSY : IDLE) :
               done ? IDLE :
               (state == INST_BUSY && !lat_we && flush) ? INST_DRAIN : state;
  end
  // request port driven from the latched copy only while a transaction is open
  always_comb begin
    mem_ce = busy;
    mem_we = busy && lat_we;
    mem_addr = busy ? lat_addr : '0;
    mem_wdata = busy ? lat_wdata : '0;
    mem_wmask = busy ? lat_wmask : '0;
    inst_rdata = mem_rdata;
    data_rdata = mem_rdata;
    inst_rdata_valid = state == INST_BUSY && !lat_we && mem_rdata_valid && !flush;
    inst_write_finish = state == INST_BUSY && lat_we && mem_write_finish;
    data_rdata_valid = state == DATA_BUSY && !lat_we && mem_rdata_valid;
    data_write_finish = state == DATA_BUSY && lat_we && mem_write_finish;
  end
  // state, request latch, last winner and grant counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lat_we <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      last_data <= 1'b0;
      grant_cnt_inst <= '0;
      grant_cnt_data <= '0;
    end else begin
      state <= state_nx;
      if (!busy && (pick_data || pick_inst)) begin
        lat_we <= pick_data ? data_we : inst_we;
        lat_addr <= pick_data ? data_addr : inst_addr;
        lat_wdata <= pick_data ? data_wdata : inst_wdata;
        lat_wmask <= pick_data ? data_wmask : inst_wmask;
        last_data <= pick_data;
      end
      if (!busy && pick_inst) grant_cnt_inst <= grant_cnt_inst + CNT_WIDTH'(1);
      if (!busy && pick_data) grant_cnt_data <= grant_cnt_data + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter in fixed-priority and round-robin modes
module tb_mem_port_arbiter;
  logic clk = 0, reset = 1, flush = 0, sel = 0;
  always #5 clk = ~clk;
  logic inst_ce = 0, inst_we = 0, data_ce = 0, data_we = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
  logic [3:0] inst_wmask = 0, data_wmask = 0;
  logic br_rv = 0, br_wf = 0, man_rv = 0, bridge_en = 1;
  logic [31:0] br_rd = 0, mem_rdata;
  logic mem_rdata_valid, mem_write_finish;
  assign mem_rdata = man_rv ? 32'h5555AAAA : br_rd;
  assign mem_rdata_valid = br_rv | man_rv;
  assign mem_write_finish = br_wf;

  logic [31:0] o_irdata[2], o_drdata[2], o_addr[2], o_wdata[2], o_cnti[2], o_cntd[2];
  logic o_irv[2], o_iwf[2], o_drv[2], o_dwf[2], o_ce[2], o_we[2];
  logic [3:0] o_wmask[2];
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(.ARB_MODE(g)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .inst_ce(inst_ce), .inst_we(inst_we), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_wmask(inst_wmask), .inst_rdata(o_irdata[g]), .inst_rdata_valid(o_irv[g]),
      .inst_write_finish(o_iwf[g]),
      .data_ce(data_ce), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_wmask(data_wmask), .data_rdata(o_drdata[g]), .data_rdata_valid(o_drv[g]),
      .data_write_finish(o_dwf[g]),
      .mem_ce(o_ce[g]), .mem_we(o_we[g]), .mem_addr(o_addr[g]), .mem_wdata(o_wdata[g]),
      .mem_wmask(o_wmask[g]), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
      .mem_write_finish(mem_write_finish),
      .grant_cnt_inst(o_cnti[g]), .grant_cnt_data(o_cntd[g])
    );
  end
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, cnt_inst, cnt_data;
  logic inst_rdata_valid, inst_write_finish, data_rdata_valid, data_write_finish, mem_ce, mem_we;
  logic [3:0] mem_wmask;
  assign inst_rdata = o_irdata[sel];
  assign data_rdata = o_drdata[sel];
  assign inst_rdata_valid = o_irv[sel];
  assign inst_write_finish = o_iwf[sel];
  assign data_rdata_valid = o_drv[sel];
  assign data_write_finish = o_dwf[sel];
  assign mem_ce = o_ce[sel];
  assign mem_we = o_we[sel];
  assign mem_addr = o_addr[sel];
  assign mem_wdata = o_wdata[sel];
  assign mem_wmask = o_wmask[sel];
  assign cnt_inst = o_cnti[sel];
  assign cnt_data = o_cntd[sel];

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wmask;} req_t;
  typedef struct packed {logic side; logic wr; logic [31:0] rdata;} rsp_t;
  req_t req_q[$];
  rsp_t rsp_q[$];
  int total = 0, bad = 0, bn = 0;
  logic pce = 0;
  req_t cur, e;
  rsp_t r;
  logic [3:0] pv;

  function automatic logic [31:0] rmap(input logic [31:0] a);
    return a == 32'h1C000000 ? 32'h02800C00 : a ^ 32'hA5A50000;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void exp_tx(input bit side, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    req_q.push_back({we, a, d, m});
    rsp_q.push_back({side, we, we ? 32'h0 : rmap(a)});
  endfunction

  task automatic do_req(input bit side, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bit got = 0;
    @(posedge clk); #1;
    if (side) begin
      data_ce = 1; data_we = we; data_addr = a; data_wdata = d; data_wmask = m;
    end else begin
      inst_ce = 1; inst_we = we; inst_addr = a; inst_wdata = d; inst_wmask = m;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = side ? (data_rdata_valid | data_write_finish) : (inst_rdata_valid | inst_write_finish);
    end
    if (!got) chk("response timeout", 0, 1);
    @(posedge clk); #1;
    if (side) data_ce = 0; else inst_ce = 0;
  endtask

  // bridge model: completes each transaction on its fourth cycle of mem_ce
  initial forever begin
    @(posedge clk); #1;
    br_rv = 0; br_wf = 0;
    if (bridge_en && mem_ce) begin
      if (bn == 3) begin
        bn = 0;
        if (mem_we) br_wf = 1;
        else begin br_rv = 1; br_rd = rmap(mem_addr); end
      end else bn++;
    end else bn = 0;
  end

  // monitor: checks each new grant and each completion pulse against the queues
  initial forever begin
    @(negedge clk);
    if (mem_ce && !pce) begin
      if (req_q.size() == 0) chk("unexpected grant", 1, 0);
      else begin
        e = req_q.pop_front();
        chk("grant req", {mem_we, mem_addr, mem_wdata, mem_wmask}, e);
      end
      cur = {mem_we, mem_addr, mem_wdata, mem_wmask};
    end else if (mem_ce) chk("req stable", {mem_we, mem_addr, mem_wdata, mem_wmask}, cur);
    pv = {inst_rdata_valid, inst_write_finish, data_rdata_valid, data_write_finish};
    if (pv != 0) begin
      if (rsp_q.size() == 0) chk("unexpected pulse", pv, 0);
      else begin
        r = rsp_q.pop_front();
        chk("pulse", pv, 4'b1000 >> {r.side, r.wr});
        if (!r.wr) chk("rdata", r.side ? data_rdata : inst_rdata, r.rdata);
      end
    end
    pce = mem_ce;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit fell;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ce", mem_ce, 0);
    chk("reset cnt", {cnt_inst, cnt_data}, 0);
    chk("reset pulses", {inst_rdata_valid, inst_write_finish, data_rdata_valid, data_write_finish}, 0);
    @(posedge clk); #1 reset = 0;
    // single inst read with latency check
    exp_tx(0, 0, 32'h1C000000, 0, 0);
    fork
      do_req(0, 0, 32'h1C000000, 0, 0);
      begin
        @(posedge clk); @(negedge clk); chk("ce at N", mem_ce, 0);
        @(negedge clk); chk("ce at N+1", mem_ce, 1);
      end
    join
    chk("t1 cnt", {cnt_inst, cnt_data}, {32'd1, 32'd0});
    // fixed priority: data before inst
    exp_tx(1, 0, 32'h1C002000, 0, 0);
    exp_tx(0, 0, 32'h1C000040, 0, 0);
    fork
      do_req(1, 0, 32'h1C002000, 0, 0);
      do_req(0, 0, 32'h1C000040, 0, 0);
    join
    chk("t2 cnt", {cnt_inst, cnt_data}, {32'd2, 32'd1});
    // data write with requester inputs changing mid-transaction
    exp_tx(1, 1, 32'h1C001000, 32'hDEADBEEF, 4'b0011);
    fork
      do_req(1, 1, 32'h1C001000, 32'hDEADBEEF, 4'b0011);
      begin
        repeat (3) @(posedge clk); #2;
        data_wdata = 0; data_wmask = 4'hF; data_addr = 0; data_we = 0;
      end
    join
    chk("t4 cnt", {cnt_inst, cnt_data}, {32'd2, 32'd2});
    // flush during inst read, data pending throughout
    req_q.push_back({1'b0, 32'h1C000080, 32'h0, 4'h0});
    exp_tx(1, 0, 32'h1C003000, 0, 0);
    @(posedge clk); #1;
    inst_ce = 1; inst_we = 0; inst_addr = 32'h1C000080; inst_wdata = 0; inst_wmask = 0;
    @(posedge clk); #1;
    flush = 1; inst_ce = 0;
    data_ce = 1; data_we = 0; data_addr = 32'h1C003000; data_wdata = 0; data_wmask = 0;
    @(posedge clk); #1 flush = 0;
    fell = 0;
    for (int i = 0; i < 40 && !fell; i++) begin
      @(negedge clk);
      fell = !mem_ce;
    end
    chk("drain end", fell, 1);
    @(negedge clk);
    chk("grant after drain", mem_ce, 1);
    fell = 0;
    for (int i = 0; i < 40 && !fell; i++) begin
      @(negedge clk);
      fell = data_rdata_valid;
    end
    chk("t5 data done", fell, 1);
    @(posedge clk); #1 data_ce = 0;
    chk("t5 cnt", {cnt_inst, cnt_data}, {32'd3, 32'd3});
    // reset mid data transaction, then a late response
    bridge_en = 0;
    req_q.push_back({1'b0, 32'h1C004000, 32'h0, 4'h0});
    @(posedge clk); #1;
    data_ce = 1; data_addr = 32'h1C004000;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1; data_ce = 0;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("t6 ce", mem_ce, 0);
    chk("t6 cnt", {cnt_inst, cnt_data}, 0);
    @(posedge clk); #1 man_rv = 1;
    @(negedge clk);
    chk("t6 late pulse", {inst_rdata_valid, data_rdata_valid}, 0);
    @(posedge clk); #1 man_rv = 0; bridge_en = 1;
    // round-robin instance: alternating grants
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 sel = 1;
    @(posedge clk); #1 reset = 0;
    for (int k = 0; k < 3; k++) begin
      exp_tx(1, 0, 32'h1C005000 + 32'(k * 4), 0, 0);
      exp_tx(0, 0, 32'h1C006000 + 32'(k * 4), 0, 0);
    end
    fork
      for (int k = 0; k < 3; k++) do_req(1, 0, 32'h1C005000 + 32'(k * 4), 0, 0);
      for (int k = 0; k < 3; k++) do_req(0, 0, 32'h1C006000 + 32'(k * 4), 0, 0);
    join
    chk("t3 cnt", {cnt_inst, cnt_data}, {32'd3, 32'd3});
    repeat (3) @(negedge clk);
    chk("req queue drained", req_q.size(), 0);
    chk("rsp queue drained", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
